// File: rtl/load_unit.sv
// Byte-serial load unit: reads 1, 2 or 4 bytes big-endian over an 8-bit memory
// port, then sign/zero-extends and holds the result until the consumer takes it.
module load_unit (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  loadops,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] base_q;
    logic [2:0]  op_q;
    logic [31:0] acc_q;
    logic [1:0]  k_q;
    logic        err_q;
    logic        last_byte;

    // Number of bytes a load kind fetches; 0 marks an illegal code.
    function automatic logic [2:0] byte_count(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU: byte_count = 3'd1;
            OP_LH, OP_LHU: byte_count = 3'd2;
            OP_LW:         byte_count = 3'd4;
            default:       byte_count = 3'd0;
        endcase
    endfunction

    function automatic logic req_illegal(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            OP_LB, OP_LBU: req_illegal = 1'b0;
            OP_LH, OP_LHU: req_illegal = addr[0];
            OP_LW:         req_illegal = (addr[1:0] != 2'b00);
            default:       req_illegal = 1'b1;
        endcase
    endfunction

    // The accumulator holds the fetched bytes right-justified, so the
    // extension only has to look at the low byte or halfword.
    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] acc);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        sb = acc[7:0];
        sh = acc[15:0];
        sx = 32'sd0;
        case (op)
            OP_LB:   sx = {{24{sb[7]}}, sb};
            OP_LH:   sx = {{16{sh[15]}}, sh};
            OP_LBU:  sx = {24'd0, acc[7:0]};
            OP_LHU:  sx = {16'd0, acc[15:0]};
            OP_LW:   sx = acc;
            default: sx = 32'sd0;
        endcase
        extend = sx;
    endfunction

    assign last_byte = ({1'b0, k_q} == (byte_count(op_q) - 3'd1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= 32'd0;
            op_q    <= 3'd0;
            acc_q   <= 32'd0;
            k_q     <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        base_q <= req_addr;
                        op_q   <= loadops;
                        acc_q  <= 32'd0;
                        k_q    <= 2'd0;
                        err_q  <= req_illegal(loadops, req_addr);
                    end
                end
                READ: begin
                    // Shift in big-endian order: the first byte ends up most significant.
                    acc_q <= {acc_q[23:0], mem_rdata};
                    k_q   <= k_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_illegal(loadops, req_addr) ? RESP : READ;
                end
            end
            READ: begin
                if (last_byte) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_rd     = 1'b0;
        mem_addr   = 32'd0;
        resp_valid = 1'b0;
        resp_data  = 32'd0;
        resp_err   = 1'b0;
        if (state_q == READ) begin
            mem_rd   = 1'b1;
            mem_addr = base_q + {30'd0, k_q};
        end
        if (state_q == RESP) begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_data  = err_q ? 32'd0 : extend(op_q, acc_q);
        end
    end

endmodule
